// File: rtl/mem_scan_if.sv
// Memory-port bundle between the scan master and a single-port data memory.
// Reads are combinational: memReadData follows address in the same cycle.
interface mem_scan_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              memRead;
  logic              memWrite;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] memWriteData;
  logic [DATA_W-1:0] memReadData;

  modport master (
    output memRead,
    output memWrite,
    output address,
    output memWriteData,
    input  memReadData
  );

  modport slave (
    input  memRead,
    input  memWrite,
    input  address,
    input  memWriteData,
    output memReadData
  );
endinterface

// File: rtl/mem_scan_master.sv
// Scans count words from baseAddr, accumulating sum, maximum and the offset of its
// first occurrence, then writes max and offset to resultAddr / resultAddr+1.
module mem_scan_master #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] baseAddr,
  input  logic [7:0]        count,
  input  logic [ADDR_W-1:0] resultAddr,
  mem_scan_if.master        bus,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] maxValue,
  output logic [7:0]        maxIndex,
  output logic [15:0]       sum
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    WR_MAX = 3'd2,
    WR_IDX = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] res_q;
  logic [7:0]        remaining;
  logic [ADDR_W-1:0] offset;
  logic              first_word;

  // count never exceeds 255, so ptr cannot come back round to base_q mid-scan
  assign offset     = ptr - base_q;
  assign first_word = (ptr == base_q);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = (count == 8'd0) ? DONE : READ;
      READ:    if (remaining == 8'd1) state_nxt = WR_MAX;
      WR_MAX:  state_nxt = WR_IDX;
      WR_IDX:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.memRead      = 1'b0;
    bus.memWrite     = 1'b0;
    bus.address      = '0;
    bus.memWriteData = '0;
    unique case (state)
      READ: begin
        bus.memRead = 1'b1;
        bus.address = ptr;
      end
      WR_MAX: begin
        bus.memWrite     = 1'b1;
        bus.address      = res_q;
        bus.memWriteData = maxValue;
      end
      WR_IDX: begin
        bus.memWrite     = 1'b1;
        bus.address      = res_q + 1'b1;
        bus.memWriteData = DATA_W'(maxIndex);
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Scan registers; results hold after DONE until the next accepted start
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr       <= '0;
      base_q    <= '0;
      res_q     <= '0;
      remaining <= '0;
      sum       <= '0;
      maxValue  <= '0;
      maxIndex  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            ptr       <= baseAddr;
            base_q    <= baseAddr;
            res_q     <= resultAddr;
            remaining <= count;
            sum       <= '0;
            maxValue  <= '0;
            maxIndex  <= '0;
          end
        end
        READ: begin
          sum <= sum + 16'(bus.memReadData);
          if (first_word || (bus.memReadData > maxValue)) begin
            maxValue <= bus.memReadData;
            maxIndex <= offset[7:0];
          end
          ptr       <= ptr + 1'b1;
          remaining <= remaining - 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_scan_master.sv
// Bench for mem_scan_master: behavioural memory, bus-transaction scoreboard and
// per-scenario tasks checking handshake timing and results.
module tb_mem_scan_master;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  baseAddr = '0;
  logic [7:0]  count = '0;
  logic [7:0]  resultAddr = '0;
  logic        busy;
  logic        done;
  logic [7:0]  maxValue;
  logic [7:0]  maxIndex;
  logic [15:0] sum;

  mem_scan_if #(.ADDR_W(8), .DATA_W(8)) bus();

  mem_scan_master #(.ADDR_W(8), .DATA_W(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .baseAddr   (baseAddr),
    .count      (count),
    .resultAddr (resultAddr),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .maxValue   (maxValue),
    .maxIndex   (maxIndex),
    .sum        (sum)
  );

  always #5 clock = ~clock;

  logic [7:0] mem [256];
  assign bus.memReadData = mem[bus.address];
  always @(posedge clock) if (bus.memWrite) mem[bus.address] = bus.memWriteData;

  typedef struct {
    int         cyc;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
  } txn_t;

  txn_t sb[$];
  txn_t mon_e;
  int   nvec = 0;
  int   nerr = 0;
  int   mcyc = 0;
  bit   mon_en = 1'b0;

  // Bus monitor: every strobe must match the head of the expected-transaction queue
  always @(negedge clock) begin
    if (mon_en) begin
      mcyc++;
      nvec++;
      if (bus.memRead && bus.memWrite) begin
        nerr++;
        $display("FAIL strobe_overlap cyc %0d: read=1 write=1, required not both", mcyc);
      end else if (bus.memRead || bus.memWrite) begin
        if (sb.size() == 0) begin
          nerr++;
          $display("FAIL unexpected_access cyc %0d: rd=%0b wr=%0b addr=%0d, required none",
                   mcyc, bus.memRead, bus.memWrite, bus.address);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.cyc != mcyc || mon_e.wr !== bus.memWrite || mon_e.addr !== bus.address ||
              (mon_e.wr && mon_e.data !== bus.memWriteData)) begin
            nerr++;
            $display("FAIL bus_txn cyc %0d: wr=%0b addr=%0d data=%0d, required cyc %0d wr=%0b addr=%0d data=%0d",
                     mcyc, bus.memWrite, bus.address, bus.memWriteData,
                     mon_e.cyc, mon_e.wr, mon_e.addr, mon_e.data);
          end
        end
      end else if (bus.address !== 8'd0 || bus.memWriteData !== 8'd0) begin
        nerr++;
        $display("FAIL idle_bus cyc %0d: addr=%0d wdata=%0d, required 0/0",
                 mcyc, bus.address, bus.memWriteData);
      end
    end
  end

  task automatic run_scan(input logic [7:0] b, input logic [7:0] n, input logic [7:0] r,
                          input logic [15:0] xsum, input logic [7:0] xmax,
                          input logic [7:0] xidx, input int poke);
    int         last;
    logic [7:0] r1;
    r1 = r + 8'd1;
    for (int i = 0; i < int'(n); i++) sb.push_back('{i + 1, 1'b0, 8'(int'(b) + i), 8'h00});
    if (n != 0) begin
      sb.push_back('{int'(n) + 1, 1'b1, r, xmax});
      sb.push_back('{int'(n) + 2, 1'b1, r1, xidx});
    end
    last = (n == 0) ? 1 : int'(n) + 3;
    @(negedge clock);
    baseAddr = b; count = n; resultAddr = r; start = 1'b1;
    @(posedge clock);
    mcyc = 0; mon_en = 1'b1;
    for (int c = 1; c <= last + 1; c++) begin
      @(negedge clock);
      nvec++;
      if (busy !== (c <= last)) begin
        nerr++;
        $display("FAIL busy base=%0d n=%0d cyc %0d: got %0b, required %0b", b, n, c, busy, c <= last);
      end
      nvec++;
      if (done !== (c == last)) begin
        nerr++;
        $display("FAIL done base=%0d n=%0d cyc %0d: got %0b, required %0b", b, n, c, done, c == last);
      end
      start = (c == poke);
      if (c == poke) begin
        baseAddr = 8'd118; count = 8'd0; resultAddr = 8'd10;
      end
    end
    mon_en = 1'b0;
    nvec++;
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL missing_txn base=%0d n=%0d: %0d left, required 0", b, n, sb.size());
      sb.delete();
    end
    nvec++;
    if (sum !== xsum) begin
      nerr++;
      $display("FAIL sum base=%0d n=%0d: got %0d, required %0d", b, n, sum, xsum);
    end
    nvec++;
    if (maxValue !== xmax) begin
      nerr++;
      $display("FAIL maxValue base=%0d n=%0d: got %0d, required %0d", b, n, maxValue, xmax);
    end
    nvec++;
    if (maxIndex !== xidx) begin
      nerr++;
      $display("FAIL maxIndex base=%0d n=%0d: got %0d, required %0d", b, n, maxIndex, xidx);
    end
    if (n != 0) begin
      nvec++;
      if (mem[r] !== xmax) begin
        nerr++;
        $display("FAIL mem_max addr=%0d: got %0d, required %0d", r, mem[r], xmax);
      end
      nvec++;
      if (mem[r1] !== xidx) begin
        nerr++;
        $display("FAIL mem_idx addr=%0d: got %0d, required %0d", r1, mem[r1], xidx);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    nvec++;
    if ({bus.memRead, bus.memWrite, busy, done} !== 4'b0000) begin
      nerr++;
      $display("FAIL reset_ctrl: rd/wr/busy/done=%b, required 0000",
               {bus.memRead, bus.memWrite, busy, done});
    end
    nvec++;
    if ({bus.address, bus.memWriteData, maxValue, maxIndex, sum} !== 48'd0) begin
      nerr++;
      $display("FAIL reset_data: addr=%0d wdata=%0d max=%0d idx=%0d sum=%0d, required all 0",
               bus.address, bus.memWriteData, maxValue, maxIndex, sum);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_four_word();
    run_scan(8'd100, 8'd4, 8'd200, 16'd101, 8'd75, 8'd2, 0);
  endtask

  task automatic test_full_scan();
    run_scan(8'd100, 8'd22, 8'd200, 16'd421, 8'd120, 8'd17, 0);
  endtask

  task automatic test_ties();
    run_scan(8'd118, 8'd4, 8'd200, 16'd4, 8'd1, 8'd0, 0);
  endtask

  task automatic test_wrap();
    mem[254] = 8'd3; mem[255] = 8'd9; mem[0] = 8'd200; mem[1] = 8'd4;
    run_scan(8'd254, 8'd4, 8'd255, 16'd216, 8'd200, 8'd2, 0);
  endtask

  task automatic test_zero_count();
    run_scan(8'd100, 8'd0, 8'd200, 16'd0, 8'd0, 8'd0, 0);
  endtask

  task automatic test_ignored_start();
    run_scan(8'd100, 8'd4, 8'd200, 16'd101, 8'd75, 8'd2, 3);
    run_scan(8'd100, 8'd4, 8'd200, 16'd101, 8'd75, 8'd2, 7);
  endtask

  task automatic test_reset_mid();
    mem[200] = 8'hAA; mem[201] = 8'h55;
    for (int i = 0; i < 3; i++) sb.push_back('{i + 1, 1'b0, 8'(100 + i), 8'h00});
    @(negedge clock);
    baseAddr = 8'd100; count = 8'd22; resultAddr = 8'd200; start = 1'b1;
    @(posedge clock);
    mcyc = 0; mon_en = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    nvec++;
    if ({bus.memRead, bus.memWrite, busy, done} !== 4'b0000) begin
      nerr++;
      $display("FAIL midreset_ctrl: rd/wr/busy/done=%b, required 0000",
               {bus.memRead, bus.memWrite, busy, done});
    end
    nvec++;
    if ({bus.address, bus.memWriteData, maxValue, maxIndex, sum} !== 48'd0) begin
      nerr++;
      $display("FAIL midreset_data: addr=%0d wdata=%0d max=%0d idx=%0d sum=%0d, required all 0",
               bus.address, bus.memWriteData, maxValue, maxIndex, sum);
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (30) @(negedge clock);
    mon_en = 1'b0;
    nvec++;
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL midreset_reads: %0d reads missing, required 0", sb.size());
      sb.delete();
    end
    nvec++;
    if (mem[200] !== 8'hAA || mem[201] !== 8'h55) begin
      nerr++;
      $display("FAIL midreset_nowrite: mem[200]=%0h mem[201]=%0h, required aa 55", mem[200], mem[201]);
    end
    run_scan(8'd100, 8'd4, 8'd200, 16'd101, 8'd75, 8'd2, 0);
  endtask

  initial begin
    logic [7:0] pre [22];
    pre = '{8'd10, 8'd7, 8'd75, 8'd9, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9,
            8'd90, 8'd10, 8'd12, 8'd13, 8'd14, 8'd15, 8'd120, 8'd1, 8'd1, 8'd1, 8'd1};
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    for (int i = 0; i < 22; i++) mem[100 + i] = pre[i];

    test_reset();
    test_four_word();
    test_full_scan();
    test_ties();
    test_wrap();
    test_zero_count();
    test_ignored_start();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
